// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame states, parity codes and oversampling ratio
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE   = 0;
  localparam int PAR_EVEN   = 1;
  localparam int PAR_ODD    = 2;
  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = PAR_NONE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       tx_done_tick
);

  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);

  uart_state_e     r_state, w_state_n;
  logic [4:0]      r_s_cnt, w_s_cnt_n;
  logic [2:0]      r_n_cnt, w_n_cnt_n;
  logic [DBIT-1:0] r_shreg, w_shreg_n;
  logic            r_par, w_par_n;
  logic            r_tx, w_tx_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_s_cnt <= w_s_cnt_n;
      r_n_cnt <= w_n_cnt_n;
      r_shreg <= w_shreg_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_s_cnt_n = r_s_cnt;
    w_n_cnt_n = r_n_cnt;
    w_shreg_n = r_shreg;
    w_par_n   = r_par;
    w_done_n  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A tick coinciding with acceptance is deliberately dropped.
        if (tx_start) begin
          w_state_n = ST_START;
          w_s_cnt_n = '0;
          w_par_n   = 1'b0;
          w_shreg_n = din[DBIT-1:0];
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (r_s_cnt == BIT_LAST) begin
            w_s_cnt_n = '0;
            w_n_cnt_n = '0;
            w_state_n = ST_DATA;
          end else begin
            w_s_cnt_n = r_s_cnt + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (r_s_cnt == BIT_LAST) begin
            w_s_cnt_n = '0;
            w_shreg_n = r_shreg >> 1;
            w_par_n   = r_par ^ r_shreg[0];
            if (r_n_cnt == DATA_LAST) begin
              w_state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              w_n_cnt_n = r_n_cnt + 3'd1;
            end
          end else begin
            w_s_cnt_n = r_s_cnt + 5'd1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (r_s_cnt == BIT_LAST) begin
            w_s_cnt_n = '0;
            w_state_n = ST_STOP;
          end else begin
            w_s_cnt_n = r_s_cnt + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (r_s_cnt == STOP_LAST) begin
            w_s_cnt_n = '0;
            w_state_n = ST_IDLE;
            w_done_n  = 1'b1;
          end else begin
            w_s_cnt_n = r_s_cnt + 5'd1;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // Line level is derived from the upcoming state so tx stays a pure register.
    case (w_state_n)
      ST_START:  w_tx_n = 1'b0;
      ST_DATA:   w_tx_n = w_shreg_n[0];
      ST_PARITY: w_tx_n = (PARITY == PAR_ODD) ? ~w_par_n : w_par_n;
      default:   w_tx_n = 1'b1;
    endcase
    w_busy_n = (w_state_n != ST_IDLE);
  end

  assign tx           = r_tx;
  assign busy         = r_busy;
  assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - randomized self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       s_tick   = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din      = 8'h00;
  logic [3:0] tx_v, busy_v, done_v;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tick_p = 3;
  int tcnt   = 0;
  logic cmp_en = 1'b0;

  int cfg_dbit[4] = '{8, 8, 8, 7};
  int cfg_sb[4]   = '{16, 16, 16, 32};
  int cfg_par[4]  = '{0, 1, 2, 0};

  always #5 clk = ~clk;

  uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_8n1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_v[0]), .busy(busy_v[0]), .tx_done_tick(done_v[0]));
  uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_8e1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_v[1]), .busy(busy_v[1]), .tx_done_tick(done_v[1]));
  uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_8o1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_v[2]), .busy(busy_v[2]), .tx_done_tick(done_v[2]));
  uart_tx_serializer #(.DBIT(7), .SB_TICK(32), .PARITY(0)) u_7n2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_v[3]), .busy(busy_v[3]), .tx_done_tick(done_v[3]));

  // Periodic tick; free-running so its phase relative to tx_start drifts.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcnt = tcnt + 1;
      if (tcnt >= tick_p) tcnt = 0;
      s_tick = (tcnt == 0);
    end
  end

  // Reference: a frame is a list of (level, length-in-ticks) segments consumed tick by tick.
  logic [3:0] m_act = '0;
  logic       m_lvl[4][12];
  int         m_len[4][12];
  int         m_nseg[4], m_idx[4], m_rem[4];
  logic [3:0] exp_tx = 4'hF, exp_busy = 4'h0, exp_done = 4'h0;

  task automatic build_frame(input int k, input logic [7:0] d);
    int n;
    logic p;
    n = 0;
    p = 1'b0;
    m_lvl[k][n] = 1'b0; m_len[k][n] = 16; n++;
    for (int i = 0; i < cfg_dbit[k]; i++) begin
      m_lvl[k][n] = d[i]; m_len[k][n] = 16; p = p ^ d[i]; n++;
    end
    if (cfg_par[k] != 0) begin
      m_lvl[k][n] = (cfg_par[k] == 2) ? ~p : p; m_len[k][n] = 16; n++;
    end
    m_lvl[k][n] = 1'b1; m_len[k][n] = cfg_sb[k]; n++;
    m_nseg[k] = n;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!reset) begin
        m_act[k] = 1'b0; exp_tx[k] = 1'b1; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
      end else begin
        exp_done[k] = 1'b0;
        if (!m_act[k]) begin
          if (tx_start) begin
            build_frame(k, din);
            m_act[k] = 1'b1; m_idx[k] = 0; m_rem[k] = m_len[k][0];
          end
        end else if (s_tick) begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) begin
            m_idx[k] = m_idx[k] + 1;
            if (m_idx[k] == m_nseg[k]) begin
              m_act[k] = 1'b0; exp_done[k] = 1'b1;
            end else begin
              m_rem[k] = m_len[k][m_idx[k]];
            end
          end
        end
        exp_tx[k]   = m_act[k] ? m_lvl[k][m_idx[k]] : 1'b1;
        exp_busy[k] = m_act[k];
      end
    end
  end

  logic log_tx[4][65536];
  int   last_done[4] = '{0, 0, 0, 0};
  int   done_cnt[4]  = '{0, 0, 0, 0};
  int   tr[$];
  logic track = 1'b0;
  logic prev0 = 1'b1;
  int   nprint = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      log_tx[k][cyc & 16'hFFFF] = tx_v[k];
      if (done_v[k] === 1'b1) begin
        last_done[k] = cyc;
        done_cnt[k]  = done_cnt[k] + 1;
      end
      if (cmp_en) begin
        checks++;
        if (tx_v[k] !== exp_tx[k] || busy_v[k] !== exp_busy[k] || done_v[k] !== exp_done[k]) begin
          errors++;
          if (nprint < 30) begin
            nprint++;
            $display("FAIL cycle_cmp dut%0d cyc %0d tx/busy/done got %b%b%b want %b%b%b",
                     k, cyc, tx_v[k], busy_v[k], done_v[k], exp_tx[k], exp_busy[k], exp_done[k]);
          end
        end
      end
    end
    if (tx_v[0] !== prev0) begin
      if (track) tr.push_back(cyc);
      prev0 = tx_v[0];
    end
    cyc++;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d);
    @(posedge clk);
    #1;
    din = d;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    din = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step();
    while ((busy_v != 4'h0 || m_act != 4'h0) && n < 4000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL wait_idle timeout busy %b model %b", busy_v, m_act);
    end
  endtask

  // Mid-bit samples of data (and parity) bits, located backwards from the done cycle.
  function automatic int decode(input int k, input int d, input int nb, input int p);
    int v;
    int idx;
    v = 0;
    for (int b = 0; b < nb; b++) begin
      idx = d - cfg_sb[k] * p - (nb - b) * 16 * p + 8 * p;
      if (log_tx[k][idx & 16'hFFFF] === 1'b1) v = v | (1 << b);
    end
    return v;
  endfunction

  initial begin
    int dc;
    int d1;
    int n;
    int hi;

    tick_p = 3;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    step();
    chk("reset_tx", int'(tx_v), 4'hF);
    chk("reset_busy", int'(busy_v), 0);
    chk("reset_done", int'(done_v), 0);
    cmp_en = 1'b1;

    // 8N1 0x55 at P=3: every bit boundary is a transition.
    tr.delete();
    track = 1'b1;
    dc = done_cnt[0];
    pulse(8'h55);
    wait_idle();
    track = 1'b0;
    chk("t55_ntrans", tr.size(), 10);
    if (tr.size() == 10) begin
      chk("t55_start_min", int'(tr[1] - tr[0] >= 46), 1);
      chk("t55_start_max", int'(tr[1] - tr[0] <= 48), 1);
      for (int i = 1; i < 9; i++) chk("t55_bit_len", tr[i+1] - tr[i], 48);
      chk("t55_stop_len", last_done[0] - tr[9], 48);
    end
    chk("t55_done_cnt", done_cnt[0] - dc, 1);
    chk("t55_data", decode(0, last_done[0], 8, 3), 'h55);
    chk("t55_data7", decode(3, last_done[3], 7, 3), 'h55);

    pulse(8'h07);
    wait_idle();
    chk("even_07", decode(1, last_done[1], 9, 3), 'h107);
    chk("odd_07", decode(2, last_done[2], 9, 3), 'h007);

    pulse(8'h00);
    wait_idle();
    chk("even_00", decode(1, last_done[1], 9, 3), 'h000);

    pulse(8'h80);
    wait_idle();
    d1 = last_done[3];
    chk("d7_data", decode(3, d1, 7, 3), 0);
    hi = 0;
    for (int c = d1 - 96; c < d1; c++) if (log_tx[3][c & 16'hFFFF] === 1'b1) hi++;
    chk("d7_stop_high", hi, 96);
    chk("d7_last_data", int'(log_tx[3][(d1 - 97) & 16'hFFFF]), 0);
    chk("d8_data80", decode(0, last_done[0], 8, 3), 'h80);

    // Back-to-back with tx_start held high.
    dc = done_cnt[0];
    @(posedge clk);
    #1 din = 8'hA3; tx_start = 1'b1;
    @(posedge clk);
    #1 din = 8'h3C;
    n = 0;
    while (done_cnt[0] == dc && n < 4000) begin step(); n++; end
    chk("b2b_first_done", done_cnt[0] - dc, 1);
    d1 = last_done[0];
    chk("b2b_first_data", decode(0, d1, 8, 3), 'hA3);
    @(posedge clk);
    #1 tx_start = 1'b0;
    step();
    chk("b2b_next_tx", int'(tx_v[0]), 0);
    chk("b2b_next_busy", int'(busy_v[0]), 1);
    wait_idle();
    chk("b2b_second_data", decode(0, last_done[0], 8, 3), 'h3C);
    chk("b2b_done_cnt", done_cnt[0] - dc, 2);

    // tx_start mid-frame is ignored.
    dc = done_cnt[0];
    pulse(8'h5A);
    repeat (100) @(posedge clk);
    pulse(8'hFF);
    wait_idle();
    chk("ignore_data", decode(0, last_done[0], 8, 3), 'h5A);
    chk("ignore_done_cnt", done_cnt[0] - dc, 1);

    // Reset during data bit 3 aborts the frame silently.
    dc = done_cnt[0];
    pulse(8'h0F);
    repeat (215) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    chk("abort_tx", int'(tx_v), 4'hF);
    chk("abort_busy", int'(busy_v), 0);
    chk("abort_done", int'(done_v), 0);
    repeat (300) step();
    chk("abort_no_done", done_cnt[0] - dc, 0);
    pulse(8'hC6);
    wait_idle();
    chk("after_abort_data", decode(0, last_done[0], 8, 3), 'hC6);
    chk("after_abort_done_cnt", done_cnt[0] - dc, 1);

    for (int it = 0; it < 40; it++) begin
      int p;
      p = int'($urandom_range(1, 4));
      tick_p = p;
      repeat ($urandom_range(0, 5)) @(posedge clk);
      pulse(8'($urandom));
      case ($urandom_range(0, 7))
        0, 1: begin
          repeat ($urandom_range(1, 150 * p)) @(posedge clk);
          pulse(8'($urandom));
        end
        2: begin
          repeat ($urandom_range(1, 160 * p)) @(posedge clk);
          #1 reset = 1'b0;
          @(posedge clk);
          #1 reset = 1'b1;
        end
        3: begin
          @(posedge clk);
          #1 tx_start = 1'b1; din = 8'($urandom);
          repeat ($urandom_range(200 * p, 400 * p)) @(posedge clk);
          #1 tx_start = 1'b0;
        end
        default: ;
      endcase
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
